// File: rtl/fu_wb_buffer.sv
// fu_wb_buffer: in-order completion FIFO between an FU and the shared writeback port.
// Optional same-cycle bypass when empty is enabled by defining FU_WB_BYPASS_EN.
`default_nettype none

module fu_wb_buffer #(
  parameter int INST_ID_BITS = 6,
  parameter int PRN_BITS     = 6,
  parameter int MAX_OPERANDS = 3,
  parameter int DEPTH        = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       fu_out_valid,
  input  logic [INST_ID_BITS-1:0]    fu_out_inst_id,
  input  logic [PRN_BITS-1:0]        fu_out_prn        [MAX_OPERANDS],
  input  logic [63:0]                fu_out_data       [MAX_OPERANDS],
  input  logic                       fu_out_data_valid [MAX_OPERANDS],
  output logic                       fu_ready,
  output logic                       wb_valid,
  input  logic                       wb_ready,
  output logic [INST_ID_BITS-1:0]    wb_inst_id,
  output logic [PRN_BITS-1:0]        wb_prn            [MAX_OPERANDS],
  output logic [63:0]                wb_data           [MAX_OPERANDS],
  output logic                       wb_data_valid     [MAX_OPERANDS],
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       overflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [PTR_W-1:0]        head_q, head_d;
  logic [PTR_W-1:0]        tail_q, tail_d;
  logic [CNT_W-1:0]        count_q, count_d;
  logic                    overflow_q, overflow_d;

  logic [INST_ID_BITS-1:0] id_q   [DEPTH];
  logic [PRN_BITS-1:0]     prn_q  [DEPTH][MAX_OPERANDS];
  logic [63:0]             data_q [DEPTH][MAX_OPERANDS];
  logic                    dv_q   [DEPTH][MAX_OPERANDS];

  logic w_full;
  logic w_empty;
  logic w_byp_take;
  logic w_byp_show;
  logic w_enq;
  logic w_deq;

  assign w_full  = (count_q == CNT_W'(DEPTH));
  assign w_empty = (count_q == '0);

`ifdef FU_WB_BYPASS_EN
  // An empty buffer forwards the FU result straight out; it is only stored if not consumed.
  assign w_byp_show = w_empty && fu_out_valid && !flush;
  assign w_byp_take = w_byp_show && wb_ready;
`else
  assign w_byp_show = 1'b0;
  assign w_byp_take = 1'b0;
`endif

  assign w_enq = fu_out_valid && !w_full && !flush && !w_byp_take;
  assign w_deq = !w_empty && wb_ready && !flush;

  always_comb begin
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    overflow_d = overflow_q | (fu_out_valid & w_full);
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (w_enq) tail_d = tail_q + PTR_W'(1);
      if (w_deq) head_d = head_q + PTR_W'(1);
      if (w_enq && !w_deq)      count_d = count_q + CNT_W'(1);
      else if (!w_enq && w_deq) count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage is reset so an empty buffer presents zeros rather than X.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int e = 0; e < DEPTH; e++) begin
        id_q[e] <= '0;
        for (int k = 0; k < MAX_OPERANDS; k++) begin
          prn_q[e][k]  <= '0;
          data_q[e][k] <= '0;
          dv_q[e][k]   <= 1'b0;
        end
      end
    end else if (w_enq) begin
      id_q[tail_q] <= fu_out_inst_id;
      for (int k = 0; k < MAX_OPERANDS; k++) begin
        prn_q[tail_q][k]  <= fu_out_prn[k];
        data_q[tail_q][k] <= fu_out_data[k];
        dv_q[tail_q][k]   <= fu_out_data_valid[k];
      end
    end
  end

  always_comb begin
    wb_valid   = !w_empty || w_byp_show;
    wb_inst_id = w_byp_show ? fu_out_inst_id : id_q[head_q];
    for (int k = 0; k < MAX_OPERANDS; k++) begin
      wb_prn[k]        = w_byp_show ? fu_out_prn[k]        : prn_q[head_q][k];
      wb_data[k]       = w_byp_show ? fu_out_data[k]       : data_q[head_q][k];
      wb_data_valid[k] = w_byp_show ? fu_out_data_valid[k] : dv_q[head_q][k];
    end
  end

  assign fu_ready = !w_full;
  assign count    = count_q;
  assign overflow = overflow_q;

endmodule

`default_nettype wire

// File: tb/tb_fu_wb_buffer.sv
// tb_fu_wb_buffer: scoreboard bench for fu_wb_buffer (default build, one-cycle latency).
`default_nettype none

module tb_fu_wb_buffer;

  localparam int D = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        flush = 1'b0;
  logic        fu_out_valid = 1'b0;
  logic [5:0]  fu_out_inst_id = '0;
  logic [5:0]  fu_out_prn [3];
  logic [63:0] fu_out_data [3];
  logic        fu_out_data_valid [3];
  logic        fu_ready;
  logic        wb_valid;
  logic        wb_ready = 1'b0;
  logic [5:0]  wb_inst_id;
  logic [5:0]  wb_prn [3];
  logic [63:0] wb_data [3];
  logic        wb_data_valid [3];
  logic [2:0]  count;
  logic        overflow;

  fu_wb_buffer #(
    .INST_ID_BITS(6), .PRN_BITS(6), .MAX_OPERANDS(3), .DEPTH(D)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .fu_out_valid(fu_out_valid), .fu_out_inst_id(fu_out_inst_id),
    .fu_out_prn(fu_out_prn), .fu_out_data(fu_out_data),
    .fu_out_data_valid(fu_out_data_valid),
    .fu_ready(fu_ready), .wb_valid(wb_valid), .wb_ready(wb_ready),
    .wb_inst_id(wb_inst_id), .wb_prn(wb_prn), .wb_data(wb_data),
    .wb_data_valid(wb_data_valid), .count(count), .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [5:0]       id;
    logic [2:0][5:0]  prn;
    logic [2:0][63:0] data;
    logic [2:0]       dv;
  } ent_t;

  ent_t sbq[$];
  ent_t m_e, m_o, m_x;
  bit   m_acc;
  int   checks = 0;
  int   errors = 0;
  int   n_out  = 0;

  // Reference model: accepted results join the expected queue at the capturing edge.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      sbq.delete();
    end else begin
      m_acc = fu_out_valid && (sbq.size() < D) && !flush;
      m_e.id = fu_out_inst_id;
      for (int k = 0; k < 3; k++) begin
        m_e.prn[k]  = fu_out_prn[k];
        m_e.data[k] = fu_out_data[k];
        m_e.dv[k]   = fu_out_data_valid[k];
      end
      if (flush) sbq.delete();
      else begin
        if (sbq.size() > 0 && wb_ready) void'(sbq.pop_front());
        if (m_acc) sbq.push_back(m_e);
      end
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      checks++;
      if (wb_valid !== (sbq.size() != 0)) begin
        errors++;
        $display("FAIL sb_wb_valid got %b expected %b", wb_valid, sbq.size() != 0);
      end
      checks++;
      if (count !== 3'(sbq.size())) begin
        errors++;
        $display("FAIL sb_count got %0d expected %0d", count, sbq.size());
      end
      checks++;
      if (fu_ready !== (sbq.size() < D)) begin
        errors++;
        $display("FAIL sb_fu_ready got %b expected %b", fu_ready, sbq.size() < D);
      end
      if (wb_valid === 1'b1 && sbq.size() != 0) begin
        m_x = sbq[0];
        m_o.id = wb_inst_id;
        for (int k = 0; k < 3; k++) begin
          m_o.prn[k]  = wb_prn[k];
          m_o.data[k] = wb_data[k];
          m_o.dv[k]   = wb_data_valid[k];
        end
        checks++;
        if (m_o !== m_x) begin
          errors++;
          $display("FAIL sb_payload got id=%0d dv=%b prn0=%0d d0=%h expected id=%0d dv=%b prn0=%0d d0=%h",
                   m_o.id, m_o.dv, m_o.prn[0], m_o.data[0], m_x.id, m_x.dv, m_x.prn[0], m_x.data[0]);
        end
        if (wb_ready) n_out++;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [5:0] id);
    fu_out_valid   = v;
    fu_out_inst_id = id;
    for (int k = 0; k < 3; k++) begin
      fu_out_prn[k]        = id + 6'(k);
      fu_out_data[k]       = {$urandom, $urandom};
      fu_out_data_valid[k] = id[k];
    end
  endtask

  task automatic test_reset();
    drive(1'b0, 6'd0);
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (wb_valid !== 1'b0 || fu_ready !== 1'b1 || count !== 3'd0 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl got v=%b rdy=%b cnt=%0d ovf=%b expected 0 1 0 0",
               wb_valid, fu_ready, count, overflow);
    end
    checks++;
    if (wb_inst_id !== 6'd0 || wb_prn[0] !== 6'd0 || wb_prn[2] !== 6'd0 ||
        wb_data[0] !== 64'd0 || wb_data[1] !== 64'd0 || wb_data_valid[0] !== 1'b0) begin
      errors++;
      $display("FAIL reset_payload got id=%0d d0=%h expected zeros", wb_inst_id, wb_data[0]);
    end
    rst = 1'b1;
    step();
  endtask

  task automatic test_single();
    wb_ready     = 1'b1;
    fu_out_valid = 1'b1;
    fu_out_inst_id = 6'd5;
    fu_out_prn[0] = 6'd10; fu_out_prn[1] = 6'd11; fu_out_prn[2] = 6'd12;
    fu_out_data[0] = 64'hA; fu_out_data[1] = 64'hB; fu_out_data[2] = 64'hC;
    fu_out_data_valid[0] = 1'b1; fu_out_data_valid[1] = 1'b0; fu_out_data_valid[2] = 1'b1;
    step();
    drive(1'b0, 6'd0);
    checks++;
    if (wb_valid !== 1'b1 || wb_inst_id !== 6'd5 || count !== 3'd1) begin
      errors++;
      $display("FAIL single_head got v=%b id=%0d cnt=%0d expected 1 5 1", wb_valid, wb_inst_id, count);
    end
    checks++;
    if (wb_prn[0] !== 6'd10 || wb_prn[1] !== 6'd11 || wb_prn[2] !== 6'd12 ||
        wb_data[0] !== 64'hA || wb_data[1] !== 64'hB || wb_data[2] !== 64'hC ||
        wb_data_valid[0] !== 1'b1 || wb_data_valid[1] !== 1'b0 || wb_data_valid[2] !== 1'b1) begin
      errors++;
      $display("FAIL single_fields got prn=%0d,%0d,%0d data=%h,%h,%h dv=%b%b%b expected 10,11,12 a,b,c 101",
               wb_prn[0], wb_prn[1], wb_prn[2], wb_data[0], wb_data[1], wb_data[2],
               wb_data_valid[0], wb_data_valid[1], wb_data_valid[2]);
    end
    step();
    checks++;
    if (count !== 3'd0 || wb_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_drain got cnt=%0d v=%b expected 0 0", count, wb_valid);
    end
  endtask

  task automatic test_overflow();
    int n0;
    wb_ready = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, 6'(i));
      step();
    end
    drive(1'b0, 6'd0);
    checks++;
    if (count !== 3'd4 || fu_ready !== 1'b0 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL full_state got cnt=%0d rdy=%b ovf=%b expected 4 0 0", count, fu_ready, overflow);
    end
    drive(1'b1, 6'd5);
    step();
    drive(1'b0, 6'd0);
    checks++;
    if (overflow !== 1'b1 || count !== 3'd4) begin
      errors++;
      $display("FAIL overflow_set got ovf=%b cnt=%0d expected 1 4", overflow, count);
    end
    n0 = n_out;
    wb_ready = 1'b1;
    repeat (5) step();
    checks++;
    if (n_out - n0 !== 4 || count !== 3'd0) begin
      errors++;
      $display("FAIL overflow_drain got outputs=%0d cnt=%0d expected 4 0", n_out - n0, count);
    end
  endtask

  task automatic test_stream();
    int n0;
    n0 = n_out;
    wb_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 6'(i));
      step();
      checks++;
      if (count > 3'd1) begin
        errors++;
        $display("FAIL stream_count got %0d expected <=1", count);
      end
    end
    drive(1'b0, 6'd0);
    repeat (2) step();
    checks++;
    if (n_out - n0 !== 16 || count !== 3'd0 || overflow !== 1'b1) begin
      errors++;
      $display("FAIL stream_total got outputs=%0d cnt=%0d ovf=%b expected 16 0 1",
               n_out - n0, count, overflow);
    end
  endtask

  task automatic test_simultaneous();
    int n0;
    n0 = n_out;
    wb_ready = 1'b0;
    drive(1'b1, 6'd20); step();
    drive(1'b1, 6'd21); step();
    checks++;
    if (count !== 3'd2) begin
      errors++;
      $display("FAIL simul_pre got cnt=%0d expected 2", count);
    end
    drive(1'b1, 6'd22);
    wb_ready = 1'b1;
    step();
    wb_ready = 1'b0;
    drive(1'b0, 6'd0);
    checks++;
    if (count !== 3'd2 || wb_inst_id !== 6'd21) begin
      errors++;
      $display("FAIL simul_hold got cnt=%0d head=%0d expected 2 21", count, wb_inst_id);
    end
    wb_ready = 1'b1;
    repeat (3) step();
    checks++;
    if (n_out - n0 !== 3 || count !== 3'd0) begin
      errors++;
      $display("FAIL simul_drain got outputs=%0d cnt=%0d expected 3 0", n_out - n0, count);
    end
  endtask

  task automatic test_flush();
    int n0;
    wb_ready = 1'b0;
    for (int i = 30; i < 33; i++) begin
      drive(1'b1, 6'(i));
      step();
    end
    checks++;
    if (count !== 3'd3) begin
      errors++;
      $display("FAIL flush_pre got cnt=%0d expected 3", count);
    end
    drive(1'b1, 6'd33);
    flush = 1'b1;
    step();
    flush = 1'b0;
    drive(1'b0, 6'd0);
    checks++;
    if (count !== 3'd0 || wb_valid !== 1'b0 || overflow !== 1'b1) begin
      errors++;
      $display("FAIL flush_post got cnt=%0d v=%b ovf=%b expected 0 0 1", count, wb_valid, overflow);
    end
    n0 = n_out;
    wb_ready = 1'b1;
    repeat (3) step();
    checks++;
    if (n_out !== n0) begin
      errors++;
      $display("FAIL flush_emit got outputs=%0d expected 0", n_out - n0);
    end
  endtask

  task automatic test_async_reset();
    wb_ready = 1'b0;
    drive(1'b1, 6'd40); step();
    drive(1'b1, 6'd41); step();
    drive(1'b0, 6'd0);
    checks++;
    if (count !== 3'd2 || overflow !== 1'b1) begin
      errors++;
      $display("FAIL areset_pre got cnt=%0d ovf=%b expected 2 1", count, overflow);
    end
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    checks++;
    if (wb_valid !== 1'b0 || count !== 3'd0 || fu_ready !== 1'b1 || overflow !== 1'b0 ||
        wb_inst_id !== 6'd0) begin
      errors++;
      $display("FAIL areset_now got v=%b cnt=%0d rdy=%b ovf=%b id=%0d expected 0 0 1 0 0",
               wb_valid, count, fu_ready, overflow, wb_inst_id);
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
    step();
    checks++;
    if (count !== 3'd0 || wb_valid !== 1'b0) begin
      errors++;
      $display("FAIL areset_after got cnt=%0d v=%b expected 0 0", count, wb_valid);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_overflow();
    test_stream();
    test_simultaneous();
    test_flush();
    test_async_reset();
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_left got %0d entries expected 0", sbq.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
